// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and defaults for the divided-clock run/stop controller.
package clk_div_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_STOP = 2'd2
   } state_t;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_HALF  = 2;

endpackage

// File: rtl/divctl_counter.sv
// Half-period counter: boundary detect, glitch-free clk_out toggle and aligned rise tick.
module divctl_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [WIDTH-1:0] half,
   output logic             boundary,
   output logic             clk_out,
   output logic             tick
);

   logic [WIDTH-1:0] cnt;

   assign boundary = (cnt == half - WIDTH'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else if (clear) begin
         cnt     <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (boundary) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
            tick    <= ~clk_out;
         end else begin
            cnt <= cnt + WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run/stop FSM, half-period config slot and valid/ready handshake around divctl_counter.
module clk_div_ctrl
   import clk_div_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH        = DEF_WIDTH,
   parameter int unsigned DEFAULT_HALF = DEF_HALF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             cfg_valid,
   input  logic [WIDTH-1:0] cfg_half,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             clk_out,
   output logic             tick,
   output logic             busy,
   output logic [WIDTH-1:0] cur_half
);

   state_t           state, next_state;
   logic             boundary;
   logic             clear;
   logic             accept;
   logic             legal;
   logic             pend_valid;
   logic [WIDTH-1:0] pend_half;

   assign cfg_ready = ~pend_valid;
   assign accept    = cfg_valid & cfg_ready;
   assign legal     = (cfg_half != '0);
   assign busy      = (state != S_IDLE);

   // Counter is held cleared in IDLE and on the cycle that enters IDLE, which
   // both truncates a low phase and produces the final falling edge.
   assign clear = (state == S_IDLE) || (next_state == S_IDLE);

   always_comb begin
      next_state = state;
      unique case (state)
         S_IDLE: if (start) next_state = S_RUN;
         S_RUN:  if (stop)  next_state = (clk_out && !boundary) ? S_STOP : S_IDLE;
         S_STOP: if (boundary) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_half   <= WIDTH'(DEFAULT_HALF);
         pend_valid <= 1'b0;
         pend_half  <= '0;
         cfg_err    <= 1'b0;
      end else begin
         cfg_err <= accept && !legal;
         if (state == S_IDLE) begin
            if (accept && legal) cur_half <= cfg_half;
         end else begin
            if (pend_valid && (boundary || next_state == S_IDLE)) begin
               cur_half   <= pend_half;
               pend_valid <= 1'b0;
            end
            // accept implies the slot was empty, so this never races the load above
            if (accept && legal) begin
               if (next_state == S_IDLE) begin
                  cur_half <= cfg_half;
               end else begin
                  pend_half  <= cfg_half;
                  pend_valid <= 1'b1;
               end
            end
         end
      end
   end

   divctl_counter #(.WIDTH(WIDTH)) u_counter (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .half     (cur_half),
      .boundary (boundary),
      .clk_out  (clk_out),
      .tick     (tick)
   );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: start/period, config timing, stop paths, cfg_err, async reset.
module tb_clk_div_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       stop;
   logic       cfg_valid;
   logic [7:0] cfg_half;
   logic       cfg_ready;
   logic       cfg_err;
   logic       clk_out;
   logic       tick;
   logic       busy;
   logic [7:0] cur_half;

   int n_tests = 0;
   int n_fail  = 0;

   clk_div_ctrl #(.WIDTH(8), .DEFAULT_HALF(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .cfg_valid (cfg_valid),
      .cfg_half  (cfg_half),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .clk_out   (clk_out),
      .tick      (tick),
      .busy      (busy),
      .cur_half  (cur_half)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [14:1] t3_clk;
      logic [14:1] t3_tick;
      reset = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_half = '0;

      // reset state
      step();
      check("rst_clk_out",   clk_out,   1'b0);
      check("rst_tick",      tick,      1'b0);
      check("rst_cfg_err",   cfg_err,   1'b0);
      check("rst_cfg_ready", cfg_ready, 1'b1);
      check("rst_busy",      busy,      1'b0);
      check("rst_cur_half",  cur_half,  8'd2);
      reset = 1'b0;
      step();
      check("idle_busy", busy, 1'b0);
      start = 1'b1;

      // default half=2: period 4, first rise 2 cycles into RUN; then stop at high cnt=0
      for (int t = 1; t <= 9; t++) begin
         logic [9:1] e_clk;
         logic [9:1] e_tick;
         e_clk  = 9'b011001100;
         e_tick = 9'b001000100;
         step();
         check($sformatf("t1_clk_out[%0d]", t), clk_out, e_clk[t]);
         check($sformatf("t1_tick[%0d]", t),    tick,    e_tick[t]);
         check($sformatf("t1_busy[%0d]", t),    busy,    (t <= 8) ? 1'b1 : 1'b0);
         if (t == 1) start = 1'b0;
         if (t == 7) stop  = 1'b1;
         if (t == 9) stop  = 1'b0;
      end

      // IDLE write half=5 applies next cycle; period 10; stop on a would-be rising boundary
      cfg_valid = 1'b1; cfg_half = 8'd5;
      step();
      check("t2_cur_half", cur_half, 8'd5);
      cfg_valid = 1'b0;
      start = 1'b1;
      for (int t = 1; t <= 16; t++) begin
         step();
         check($sformatf("t2_clk_out[%0d]", t), clk_out, (t >= 6 && t <= 10) ? 1'b1 : 1'b0);
         check($sformatf("t2_tick[%0d]", t),    tick,    (t == 6) ? 1'b1 : 1'b0);
         check($sformatf("t2_busy[%0d]", t),    busy,    (t <= 15) ? 1'b1 : 1'b0);
         if (t == 1)  start = 1'b0;
         if (t == 15) stop  = 1'b1;
         if (t == 16) stop  = 1'b0;
      end

      // back to half=2, then change to 3 mid-phase; zero write; pending write on a boundary
      cfg_valid = 1'b1; cfg_half = 8'd2;
      step();
      check("t3_cur_half_init", cur_half, 8'd2);
      cfg_valid = 1'b0;
      start = 1'b1;
      t3_clk  = 14'b10001110001100;
      t3_tick = 14'b10000010000100;
      for (int t = 1; t <= 14; t++) begin
         step();
         check($sformatf("t3_clk_out[%0d]", t),   clk_out,   t3_clk[t]);
         check($sformatf("t3_tick[%0d]", t),      tick,      t3_tick[t]);
         check($sformatf("t3_cfg_ready[%0d]", t), cfg_ready, (t == 4 || t == 14) ? 1'b0 : 1'b1);
         check($sformatf("t3_cur_half[%0d]", t),  cur_half,  (t <= 4) ? 8'd2 : 8'd3);
         check($sformatf("t3_cfg_err[%0d]", t),   cfg_err,   (t == 13) ? 1'b1 : 1'b0);
         if (t == 1)  start = 1'b0;
         if (t == 3)  begin cfg_valid = 1'b1; cfg_half = 8'd3; end
         if (t == 4)  cfg_valid = 1'b0;
         if (t == 12) begin cfg_valid = 1'b1; cfg_half = 8'd0; end
         if (t == 13) cfg_half = 8'd7;
         if (t == 14) cfg_valid = 1'b0;
      end

      // asynchronous reset while RUN with clk_out high and a value pending
      #2 reset = 1'b1;
      #1;
      check("arst_clk_out",   clk_out,   1'b0);
      check("arst_tick",      tick,      1'b0);
      check("arst_cfg_err",   cfg_err,   1'b0);
      check("arst_cfg_ready", cfg_ready, 1'b1);
      check("arst_busy",      busy,      1'b0);
      check("arst_cur_half",  cur_half,  8'd2);
      step();
      reset = 1'b0;
      step();
      step();
      check("post_rst_cur_half",  cur_half,  8'd2);
      check("post_rst_cfg_ready", cfg_ready, 1'b1);
      check("post_rst_busy",      busy,      1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
